// File: rtl/rot_buffer_scheduler.sv
// Arbitrates one frame-buffer port between column reads, frame blanking and point writes.
// Points wait in a small FWFT queue; display ticks and clear requests are latched so none is lost.
module rot_buffer_scheduler #(
    parameter  int ROTATIONAL_RES = 1024,
    parameter  int DISPLAY_RADIUS = 32,
    parameter  int DISPLAY_HEIGHT = 64,
    parameter  int FIFO_DEPTH     = 16,
    localparam int TW             = $clog2(ROTATIONAL_RES),
    localparam int RW             = $clog2(DISPLAY_RADIUS),
    localparam int ZW             = $clog2(DISPLAY_HEIGHT),
    localparam int AW             = $clog2(FIFO_DEPTH),
    localparam int CW             = AW + 1
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          pt_valid,
    output logic          pt_ready,
    input  logic [RW-1:0] pt_radius,
    input  logic [TW-1:0] pt_theta,
    input  logic [ZW-1:0] pt_z,
    input  logic          clear_req,
    input  logic          theta_tick,
    input  logic [TW-1:0] theta_now,
    input  logic          buf_busy,
    output logic          buf_flush,
    output logic          buf_new_data,
    output logic [RW-1:0] buf_radius,
    output logic [TW-1:0] buf_theta_write,
    output logic [ZW-1:0] buf_z,
    output logic [TW-1:0] buf_theta_read,
    output logic          read_valid,
    output logic          clear_busy,
    output logic [CW-1:0] fifo_count,
    output logic          read_overrun
);

    typedef struct packed {
        logic [RW-1:0] radius;
        logic [TW-1:0] theta;
        logic [ZW-1:0] z;
    } point_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ_HOLD,
        ST_FLUSH_ISSUE,
        ST_FLUSH_WAIT,
        ST_WRITE_ISSUE,
        ST_WRITE_WAIT
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [1:0]    state_cnt;

    logic          rd_pending;
    logic [TW-1:0] rd_theta;
    logic          clr_pending;

    point_t        fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    point_t        fifo_head;

    logic          push;
    logic          rd_take;
    logic          wr_take;
    logic          flush_take;

    assign fifo_head  = fifo_mem[rd_ptr];
    assign clear_busy = clr_pending || (state == ST_FLUSH_ISSUE) || (state == ST_FLUSH_WAIT);
    assign pt_ready   = rst_n_in && (fifo_count < CW'(FIFO_DEPTH)) && !clear_busy && !clear_req;
    assign push       = pt_valid && pt_ready;

    assign rd_take    = (state == ST_IDLE) && (state_next == ST_READ_HOLD);
    assign wr_take    = (state == ST_IDLE) && (state_next == ST_WRITE_ISSUE);
    assign flush_take = (state == ST_FLUSH_ISSUE);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next   = state;
        buf_flush    = 1'b0;
        buf_new_data = 1'b0;
        read_valid   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!buf_busy) begin
                    if (rd_pending)
                        state_next = ST_READ_HOLD;
                    else if (clr_pending)
                        state_next = ST_FLUSH_ISSUE;
                    // A write is not started on the edge that discards the queue.
                    else if ((fifo_count != '0) && !clear_req)
                        state_next = ST_WRITE_ISSUE;
                end
            end
            ST_READ_HOLD: begin
                read_valid = (state_cnt == 2'd2);
                if (state_cnt == 2'd2)
                    state_next = ST_IDLE;
            end
            ST_FLUSH_ISSUE: begin
                buf_flush  = 1'b1;
                state_next = ST_FLUSH_WAIT;
            end
            ST_FLUSH_WAIT: begin
                if (!buf_busy && (state_cnt >= 2'd1))
                    state_next = ST_IDLE;
            end
            ST_WRITE_ISSUE: begin
                buf_new_data = 1'b1;
                state_next   = ST_WRITE_WAIT;
            end
            ST_WRITE_WAIT: begin
                if (!buf_busy && (state_cnt >= 2'd2))
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state           <= ST_IDLE;
            state_cnt       <= '0;
            rd_pending      <= 1'b0;
            rd_theta        <= '0;
            clr_pending     <= 1'b0;
            read_overrun    <= 1'b0;
            buf_theta_read  <= '0;
            buf_radius      <= '0;
            buf_theta_write <= '0;
            buf_z           <= '0;
        end else begin
            state <= state_next;
            if (state_next != state)
                state_cnt <= '0;
            else if (state_cnt != 2'd3)
                state_cnt <= state_cnt + 2'd1;

            // A tick on the consuming edge starts a fresh request rather than overrunning.
            if (theta_tick) begin
                rd_theta   <= theta_now;
                rd_pending <= 1'b1;
                if (rd_pending && !rd_take)
                    read_overrun <= 1'b1;
            end else if (rd_take) begin
                rd_pending <= 1'b0;
            end

            if (rd_take)
                buf_theta_read <= rd_theta;

            if (clear_req && !clear_busy)
                clr_pending <= 1'b1;
            else if (flush_take)
                clr_pending <= 1'b0;

            if (wr_take) begin
                buf_radius      <= fifo_head.radius;
                buf_theta_write <= fifo_head.theta;
                buf_z           <= fifo_head.z;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (clear_req) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (wr_take)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, wr_take})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // NOTE: queue storage is not reset; the pointers and count alone define which entries are live.
    always_ff @(posedge clk_in) begin
        if (push)
            fifo_mem[wr_ptr] <= '{radius: pt_radius, theta: pt_theta, z: pt_z};
    end

endmodule

// File: tb/tb_rot_buffer_scheduler.sv
// Self-checking bench for rot_buffer_scheduler: cycle table, directed corner sequences,
// then random traffic against a queue-level model with a simple frame-buffer busy model.
module tb_rot_buffer_scheduler;

    localparam int TW = 10;
    localparam int RW = 5;
    localparam int ZW = 6;
    localparam int CW = 5;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic          pt_valid;
    logic          pt_ready;
    logic [RW-1:0] pt_radius;
    logic [TW-1:0] pt_theta;
    logic [ZW-1:0] pt_z;
    logic          clear_req;
    logic          theta_tick;
    logic [TW-1:0] theta_now;
    logic          buf_busy;
    logic          buf_flush;
    logic          buf_new_data;
    logic [RW-1:0] buf_radius;
    logic [TW-1:0] buf_theta_write;
    logic [ZW-1:0] buf_z;
    logic [TW-1:0] buf_theta_read;
    logic          read_valid;
    logic          clear_busy;
    logic [CW-1:0] fifo_count;
    logic          read_overrun;

    rot_buffer_scheduler dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .pt_valid        (pt_valid),
        .pt_ready        (pt_ready),
        .pt_radius       (pt_radius),
        .pt_theta        (pt_theta),
        .pt_z            (pt_z),
        .clear_req       (clear_req),
        .theta_tick      (theta_tick),
        .theta_now       (theta_now),
        .buf_busy        (buf_busy),
        .buf_flush       (buf_flush),
        .buf_new_data    (buf_new_data),
        .buf_radius      (buf_radius),
        .buf_theta_write (buf_theta_write),
        .buf_z           (buf_z),
        .buf_theta_read  (buf_theta_read),
        .read_valid      (read_valid),
        .clear_busy      (clear_busy),
        .fifo_count      (fifo_count),
        .read_overrun    (read_overrun)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int tick, th, vld, r, t, z, clr;
        int e_rv, e_btr, e_nd, e_fl, e_cb, e_cnt, e_r, e_t, e_z;
    } vec_t;
    vec_t tbl [16];

    typedef struct { int r, t, z; } pt_t;
    pt_t mq[$];
    int  tq[$];
    int  busy_cnt = 0;
    int  theta_seq = 100;
    bit  p_hs, p_clr, p_tick;
    int  p_th;
    pt_t p_pt;

    task automatic idle_inputs();
        pt_valid = 0; pt_radius = '0; pt_theta = '0; pt_z = '0;
        clear_req = 0; theta_tick = 0; theta_now = '0;
    endtask

    task automatic push_point(input int r, input int t, input int z);
        pt_valid = 1; pt_radius = RW'(r); pt_theta = TW'(t); pt_z = ZW'(z);
        #1 check("push_ready", int'(pt_ready), 1);
        @(negedge clk_in);
        pt_valid = 0;
    endtask

    task automatic wait_flush(input int limit, output int found);
        found = 0;
        for (int c = 0; c < limit && found == 0; c++) begin
            @(negedge clk_in);
            clear_req = 0;
            if (buf_flush) found = 1;
        end
    endtask

    // One random-phase cycle: account for the previous edge, check, then drive the next cycle.
    task automatic rand_cycle(input bit active);
        pt_t exp_pt;
        int  idx;
        @(negedge clk_in);
        if (p_clr) mq.delete();
        else if (p_hs) mq.push_back(p_pt);
        if (p_tick) tq.push_back(p_th);
        if (buf_new_data) begin
            check("rnd_wr_avail", int'(mq.size() > 0), 1);
            check("rnd_wr_during_clear", int'(clear_busy), 0);
            if (mq.size() > 0) begin
                exp_pt = mq.pop_front();
                check("rnd_wr_radius", int'(buf_radius), exp_pt.r);
                check("rnd_wr_theta", int'(buf_theta_write), exp_pt.t);
                check("rnd_wr_z", int'(buf_z), exp_pt.z);
            end
        end
        check("rnd_fifo_count", int'(fifo_count), mq.size());
        if (read_valid) begin
            idx = -1;
            foreach (tq[i]) if (idx < 0 && tq[i] == int'(buf_theta_read)) idx = i;
            check("rnd_read_theta", int'(idx >= 0), 1);
            for (int k = 0; k <= idx; k++) void'(tq.pop_front());
        end
        if (buf_new_data) busy_cnt = $urandom_range(0, 4);
        else if (buf_flush) busy_cnt = $urandom_range(1, 30);
        else if (busy_cnt > 0) busy_cnt--;
        else if (active && $urandom_range(0, 99) < 3) busy_cnt = 1;
        buf_busy = (busy_cnt > 0);
        idle_inputs();
        if (active) begin
            pt_valid  = ($urandom_range(0, 99) < 60);
            pt_radius = RW'($urandom);
            pt_theta  = TW'($urandom);
            pt_z      = ZW'($urandom);
            clear_req = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) < 5 && theta_seq < 1000) begin
                theta_seq += $urandom_range(1, 3);
                theta_tick = 1;
                theta_now  = TW'(theta_seq);
            end
        end
        #1;
        p_hs   = pt_valid && pt_ready;
        p_clr  = clear_req;
        p_tick = theta_tick;
        p_th   = int'(theta_now);
        p_pt   = '{int'(pt_radius), int'(pt_theta), int'(pt_z)};
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int found, nd_cnt, last, rv_cnt, rv_cyc, fl_cyc, fl_cnt, rd_val;
        int p_r[3] = '{4, 17, 31};
        int p_t[3] = '{600, 3, 1023};
        int p_z[3] = '{10, 63, 0};

        //        tick th  vld r  t    z   clr | rv btr nd fl cb cnt r  t    z
        tbl[0]  = '{1, 5,  0, 0, 0,   0,  0,   0, 0,  0, 0, 0, 0,  0, 0,   0};
        tbl[1]  = '{0, 0,  0, 0, 0,   0,  0,   0, 5,  0, 0, 0, 0,  0, 0,   0};
        tbl[2]  = '{0, 0,  0, 0, 0,   0,  0,   0, 5,  0, 0, 0, 0,  0, 0,   0};
        tbl[3]  = '{0, 0,  0, 0, 0,   0,  0,   1, 5,  0, 0, 0, 0,  0, 0,   0};
        tbl[4]  = '{0, 0,  0, 0, 0,   0,  0,   0, 5,  0, 0, 0, 0,  0, 0,   0};
        tbl[5]  = '{0, 0,  1, 4, 600, 10, 0,   0, 5,  0, 0, 0, 1,  0, 0,   0};
        tbl[6]  = '{0, 0,  0, 0, 0,   0,  0,   0, 5,  1, 0, 0, 0,  4, 600, 10};
        tbl[7]  = '{0, 0,  0, 0, 0,   0,  0,   0, 5,  0, 0, 0, 0,  4, 600, 10};
        tbl[8]  = '{0, 0,  0, 0, 0,   0,  1,   0, 5,  0, 0, 1, 0,  4, 600, 10};
        tbl[9]  = '{0, 0,  0, 0, 0,   0,  0,   0, 5,  0, 0, 1, 0,  4, 600, 10};
        tbl[10] = '{0, 0,  0, 0, 0,   0,  0,   0, 5,  0, 0, 1, 0,  4, 600, 10};
        tbl[11] = '{0, 0,  0, 0, 0,   0,  0,   0, 5,  0, 1, 1, 0,  4, 600, 10};
        tbl[12] = '{0, 0,  0, 0, 0,   0,  0,   0, 5,  0, 0, 1, 0,  4, 600, 10};
        tbl[13] = '{0, 0,  0, 0, 0,   0,  0,   0, 5,  0, 0, 1, 0,  4, 600, 10};
        tbl[14] = '{0, 0,  0, 0, 0,   0,  0,   0, 5,  0, 0, 0, 0,  4, 600, 10};
        tbl[15] = '{0, 0,  0, 0, 0,   0,  0,   0, 5,  0, 0, 0, 0,  4, 600, 10};

        rst_n_in = 0;
        buf_busy = 0;
        idle_inputs();
        repeat (3) @(negedge clk_in);
        check("rst_pt_ready", int'(pt_ready), 0);
        check("rst_fifo_count", int'(fifo_count), 0);
        check("rst_clear_busy", int'(clear_busy), 0);
        check("rst_read_valid", int'(read_valid), 0);
        check("rst_cmds", int'({buf_flush, buf_new_data}), 0);
        check("rst_overrun", int'(read_overrun), 0);
        rst_n_in = 1;
        #1 check("release_pt_ready", int'(pt_ready), 1);

        foreach (tbl[i]) begin
            theta_tick = tbl[i].tick[0];
            theta_now  = TW'(tbl[i].th);
            pt_valid   = tbl[i].vld[0];
            pt_radius  = RW'(tbl[i].r);
            pt_theta   = TW'(tbl[i].t);
            pt_z       = ZW'(tbl[i].z);
            clear_req  = tbl[i].clr[0];
            @(negedge clk_in);
            check($sformatf("tbl%0d_read_valid", i), int'(read_valid), tbl[i].e_rv);
            check($sformatf("tbl%0d_theta_read", i), int'(buf_theta_read), tbl[i].e_btr);
            check($sformatf("tbl%0d_new_data", i), int'(buf_new_data), tbl[i].e_nd);
            check($sformatf("tbl%0d_flush", i), int'(buf_flush), tbl[i].e_fl);
            check($sformatf("tbl%0d_clear_busy", i), int'(clear_busy), tbl[i].e_cb);
            check($sformatf("tbl%0d_fifo_count", i), int'(fifo_count), tbl[i].e_cnt);
            check($sformatf("tbl%0d_operands", i),
                  int'({buf_radius, buf_theta_write, buf_z}),
                  (tbl[i].e_r << (TW + ZW)) | (tbl[i].e_t << ZW) | tbl[i].e_z);
        end
        idle_inputs();

        // Three queued points drain in push order with at least 4 cycles between commands.
        buf_busy = 1;
        for (int k = 0; k < 3; k++) push_point(p_r[k], p_t[k], p_z[k]);
        check("q3_count_full", int'(fifo_count), 3);
        buf_busy = 0;
        nd_cnt = 0;
        last = -100;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk_in);
            if (buf_new_data) begin
                if (nd_cnt < 3) begin
                    check("q3_radius", int'(buf_radius), p_r[nd_cnt]);
                    check("q3_theta", int'(buf_theta_write), p_t[nd_cnt]);
                    check("q3_z", int'(buf_z), p_z[nd_cnt]);
                end
                if (nd_cnt > 0) check("q3_spacing_ge4", int'(c - last >= 4), 1);
                last = c;
                nd_cnt++;
            end
        end
        check("q3_pulses", nd_cnt, 3);
        check("q3_count_empty", int'(fifo_count), 0);

        // Clear with five queued points and a long flush; a repeat clear must coalesce.
        buf_busy = 1;
        for (int k = 0; k < 5; k++) push_point(k + 1, 100 * k, 2 * k);
        check("clr_count_before", int'(fifo_count), 5);
        clear_req = 1;
        #1 check("clr_ready_same_cycle", int'(pt_ready), 0);
        @(negedge clk_in);
        clear_req = 0;
        pt_valid = 1;
        check("clr_fifo_emptied", int'(fifo_count), 0);
        check("clr_busy_set", int'(clear_busy), 1);
        repeat (3) @(negedge clk_in);
        buf_busy = 0;
        wait_flush(10, found);
        check("clr_flush_seen", found, 1);
        fl_cnt = found;
        buf_busy = 1;
        for (int c = 0; c < 513; c++) begin
            @(negedge clk_in);
            clear_req = (c == 100);
            if (buf_flush) fl_cnt++;
            if (clear_busy !== 1'b1 || pt_ready !== 1'b0 || c == 512) begin
                check("clr_hold_busy", int'(clear_busy), 1);
                check("clr_hold_ready", int'(pt_ready), 0);
            end
        end
        buf_busy = 0;
        pt_valid = 0;
        found = 0;
        for (int c = 0; c < 5 && found == 0; c++) begin
            @(negedge clk_in);
            if (!clear_busy) found = 1;
        end
        check("clr_busy_drops", found, 1);
        repeat (10) begin
            @(negedge clk_in);
            if (buf_flush) fl_cnt++;
        end
        check("clr_single_flush", fl_cnt, 1);
        check("clr_ready_after", int'(pt_ready), 1);
        check("overrun_clean", int'(read_overrun), 0);

        // Two ticks during a write collapse into one read of the newer slot.
        push_point(9, 9, 9);
        found = 0;
        for (int c = 0; c < 10 && found == 0; c++) begin
            if (buf_new_data) found = 1;
            else @(negedge clk_in);
        end
        check("ovr_write_started", found, 1);
        @(negedge clk_in);
        theta_tick = 1; theta_now = 10'd7;
        @(negedge clk_in);
        theta_now = 10'd8;
        @(negedge clk_in);
        theta_tick = 0;
        rv_cnt = 0;
        rd_val = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_in);
            if (read_valid) begin rv_cnt++; rd_val = int'(buf_theta_read); end
        end
        check("ovr_one_read", rv_cnt, 1);
        check("ovr_read_theta", rd_val, 8);
        check("ovr_sticky", int'(read_overrun), 1);

        // Tick and clear together with points queued: read first, then flush, no write.
        buf_busy = 1;
        push_point(1, 2, 3);
        push_point(4, 5, 6);
        buf_busy = 0;
        theta_tick = 1; theta_now = 10'd9; clear_req = 1;
        @(negedge clk_in);
        idle_inputs();
        rv_cyc = -1; fl_cyc = -1; nd_cnt = 0; fl_cnt = 0; rd_val = -1;
        for (int c = 0; c < 40; c++) begin
            if (read_valid && rv_cyc < 0) begin rv_cyc = c; rd_val = int'(buf_theta_read); end
            if (buf_flush) begin fl_cnt++; if (fl_cyc < 0) fl_cyc = c; end
            if (buf_new_data) nd_cnt++;
            @(negedge clk_in);
        end
        check("tc_read_theta", rd_val, 9);
        check("tc_one_flush", fl_cnt, 1);
        check("tc_read_before_flush", int'(rv_cyc >= 0 && fl_cyc > rv_cyc), 1);
        check("tc_no_write", nd_cnt, 0);
        check("tc_fifo_empty", int'(fifo_count), 0);

        // Asynchronous reset in the middle of a flush wait.
        clear_req = 1;
        wait_flush(10, found);
        check("rstf_flush_seen", found, 1);
        buf_busy = 1;
        repeat (2) @(negedge clk_in);
        check("rstf_in_flush_wait", int'(clear_busy), 1);
        #2 rst_n_in = 0;
        #1;
        check("rstf_clear_busy", int'(clear_busy), 0);
        check("rstf_pt_ready", int'(pt_ready), 0);
        check("rstf_cmds", int'({buf_flush, buf_new_data, read_valid}), 0);
        check("rstf_operands", int'({buf_radius, buf_theta_write, buf_z}), 0);
        check("rstf_theta_read", int'(buf_theta_read), 0);
        check("rstf_overrun", int'(read_overrun), 0);
        check("rstf_fifo_count", int'(fifo_count), 0);
        @(negedge clk_in);
        buf_busy = 0;
        rst_n_in = 1;
        #1 check("rstf_ready_release", int'(pt_ready), 1);
        fl_cnt = 0; nd_cnt = 0;
        repeat (10) begin
            @(negedge clk_in);
            if (buf_flush) fl_cnt++;
            if (buf_new_data) nd_cnt++;
        end
        check("rstf_no_reissue", fl_cnt + nd_cnt, 0);
        check("rstf_fifo_after", int'(fifo_count), 0);

        // Random traffic against the queue-level model.
        p_hs = 0; p_clr = 0; p_tick = 0;
        for (int c = 0; c < 2500; c++) rand_cycle(1'b1);
        for (int c = 0; c < 300; c++) rand_cycle(1'b0);
        check("rnd_model_drained", mq.size(), 0);
        check("rnd_last_tick_read", tq.size(), 0);
        check("rnd_clear_idle", int'(clear_busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rot_buffer_scheduler.md
ROT_BUFFER_SCHEDULER -- requirements
Module: rot_buffer_scheduler

Interface
REQ-001 Parameter ROTATIONAL_RES, 1024, angular slots per revolution (TW = clog2).
REQ-002 Parameter DISPLAY_RADIUS, 32, radial positions (RW = clog2).
REQ-003 Parameter DISPLAY_HEIGHT, 64, vertical LEDs (ZW = clog2).
REQ-004 Parameter FIFO_DEPTH, 16, point queue entries, power of two.
REQ-005 Clocking: one clock; reset is asynchronous and active-low.
REQ-006 clk_in  in  1  sole clock, rising edge.
REQ-007 rst_n_in  in  1  asynchronous active-low reset.
REQ-008 pt_valid  in  1  point offered; pt_ready  out  1  point accepted when both high.
REQ-009 pt_radius  in  RW; pt_theta  in  TW; pt_z  in  ZW  point coordinates.
REQ-010 clear_req  in  1  single-cycle request to blank the frame buffer.
REQ-011 theta_tick  in  1  display advanced one slot; theta_now  in  TW  new slot.
REQ-012 buf_busy  in  1  busy from the frame buffer.
REQ-013 buf_flush, buf_new_data  out  1  single-cycle commands to the frame buffer.
REQ-014 buf_radius RW, buf_theta_write TW, buf_z ZW, buf_theta_read TW  out  buffer operands.
REQ-015 read_valid  out  1  buffer column outputs valid for buf_theta_read this cycle.
REQ-016 clear_busy  out  1; fifo_count  out  clog2(FIFO_DEPTH)+1; read_overrun  out  1 sticky.

Function
REQ-017 Point FIFO: pt_ready = (fifo_count < FIFO_DEPTH) and no clear pending/active; push on handshake; first-word-fall-through ordering preserved.
REQ-018 States: IDLE, READ_HOLD, FLUSH_ISSUE, FLUSH_WAIT, WRITE_ISSUE, WRITE_WAIT.
REQ-019 theta_tick latches theta_now into rd_theta and sets rd_pending; tick while rd_pending already set overwrites rd_theta and sets read_overrun.
REQ-020 clear_req sets clr_pending; repeated clear_req while pending or flushing coalesces (one flush).
REQ-021 clear_req discards all FIFO entries at the same edge; fifo_count = 0 next cycle.
REQ-022 IDLE priority, evaluated only when buf_busy = 0: rd_pending -> READ_HOLD; else clr_pending -> FLUSH_ISSUE; else FIFO non-empty -> WRITE_ISSUE; else stay.
REQ-023 READ_HOLD: buf_theta_read = rd_theta, clear rd_pending on entry, hold 3 cycles; read_valid = 1 on third cycle only; return IDLE.
REQ-024 Outside READ_HOLD buf_theta_read holds last rd_theta.
REQ-025 FLUSH_ISSUE: buf_flush = 1 for one cycle, clear clr_pending, go FLUSH_WAIT.
REQ-026 FLUSH_WAIT: exit to IDLE when buf_busy = 0 and at least 2 cycles spent in state.
REQ-027 clear_busy = 1 from clear_req edge through last FLUSH_WAIT cycle.
REQ-028 WRITE_ISSUE: pop FIFO head onto buf_radius/buf_theta_write/buf_z, buf_new_data = 1 one cycle; operands held stable until next WRITE_ISSUE.
REQ-029 WRITE_WAIT: exit to IDLE when buf_busy = 0 and at least 3 cycles spent (covers buffer commit cycle).
REQ-030 Ticks and clears arriving in any non-IDLE state are latched, never lost; serviced at next IDLE per REQ-022.
REQ-031 Simultaneous push and pop same cycle: fifo_count unchanged.
REQ-032 pt_theta >= ROTATIONAL_RES impossible by width; no range checks.

Reset
REQ-033 While rst_n_in = 0: state IDLE, FIFO empty, rd_pending, clr_pending, read_overrun = 0, all buf_* outputs 0, read_valid 0, clear_busy 0, pt_ready 0.
REQ-034 Reset mid-write or mid-flush abandons operation; no command re-issued after release.
REQ-035 pt_ready rises first cycle after reset release.

Verification
REQ-036 Tick theta_now=5 from IDLE, buf_busy=0 -> buf_theta_read=5 next 3 cycles, read_valid on 3rd, then IDLE.
REQ-037 Push 3 points (r=4,t=600,z=10 ...) -> three buf_new_data pulses in push order, spacing >= 4 cycles, fifo_count 3->0.
REQ-038 clear_req with 5 queued points, buf_busy high 513 cycles -> FIFO empties, one buf_flush, clear_busy high until busy falls, pt_ready low throughout.
REQ-039 Tick during WRITE_WAIT, then second tick (theta 7 then 8) before IDLE -> one READ_HOLD with theta 8, read_overrun = 1.
REQ-040 Tick and clear_req same cycle with points queued -> READ_HOLD first, then flush, no write.
REQ-041 Assert rst_n_in low during FLUSH_WAIT -> all outputs reset values asynchronously; FIFO empty after release.
